// File: rtl/perip_led_bz_pwm_if.sv
// Register-bank to LED/buzzer/PWM pin bundle: five 32-bit settings in, six pin-level outputs back.
// No latency or backpressure of its own; master drives the settings, slave drives the pins.
interface perip_led_bz_pwm_if;
    logic [31:0] LED_FREQ;
    logic [31:0] BZ_FREQ;
    logic [31:0] LEDR_Puty;
    logic [31:0] LEDG_Puty;
    logic [31:0] LEDB_Puty;
    logic        LED_BLINK;
    logic        BZ_OUT;
    logic        LEDR_PWM;
    logic        LEDG_PWM;
    logic        LEDB_PWM;
    logic        PWM_PERIOD_END;

    modport master (
        output LED_FREQ, BZ_FREQ, LEDR_Puty, LEDG_Puty, LEDB_Puty,
        input  LED_BLINK, BZ_OUT, LEDR_PWM, LEDG_PWM, LEDB_PWM, PWM_PERIOD_END
    );

    modport slave (
        input  LED_FREQ, BZ_FREQ, LEDR_Puty, LEDG_Puty, LEDB_Puty,
        output LED_BLINK, BZ_OUT, LEDR_PWM, LEDG_PWM, LEDB_PWM, PWM_PERIOD_END
    );
endinterface

// File: rtl/perip_led_bz_pwm.sv
// Blink, buzzer and RGB PWM generators; every pin is registered (1 CLK from counter state to pin).
// No backpressure: settings are sampled continuously, duties are shadowed and only adopted at PWM period wrap.
module perip_led_bz_pwm #(
    parameter int PWM_W = 8,
    parameter int PRESC = 100
) (
    input  logic              CLK,
    input  logic              RST,
    perip_led_bz_pwm_if.slave bus
);
    localparam int              PCW        = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PCW-1:0]  PRESC_LAST = PCW'(PRESC - 1);
    localparam logic [31:0]     DUTY_MAX32 = 32'd1 << PWM_W;
    localparam logic [PWM_W:0]  DUTY_MAX   = {1'b1, {PWM_W{1'b0}}};

    function automatic logic [PWM_W:0] sat_duty(input logic [31:0] d);
        return (d >= DUTY_MAX32) ? DUTY_MAX : d[PWM_W:0];
    endfunction

    // Returns {out_next, cnt_next}; the >= compare wraps at once when freq is lowered below cnt.
    function automatic logic [32:0] sq_next(input logic [31:0] freq, input logic [31:0] cnt,
                                            input logic o);
        if (freq == 32'd0)
            return 33'd0;
        else if (cnt >= freq - 32'd1)
            return {~o, 32'd0};
        else
            return {o, cnt + 32'd1};
    endfunction

    logic [PCW-1:0]         presc_cnt_q, presc_cnt_d;
    logic [PWM_W-1:0]       pwm_cnt_q, pwm_cnt_d;
    logic [2:0][PWM_W:0]    duty_sh_q, duty_sh_d;
    logic [2:0]             pwm_q, pwm_d;
    logic                   pend_q, pend_d;
    logic [31:0]            bl_cnt_q, bl_cnt_d;
    logic                   led_blink_q, led_blink_d;
    logic [31:0]            bz_cnt_q, bz_cnt_d;
    logic                   bz_out_q, bz_out_d;
    logic [2:0][31:0]       duty_in;
    logic                   tick;
    logic                   period_end;

    always_comb begin
        duty_in     = {bus.LEDB_Puty, bus.LEDG_Puty, bus.LEDR_Puty};
        tick        = (presc_cnt_q == PRESC_LAST);
        period_end  = tick && (pwm_cnt_q == {PWM_W{1'b1}});
        presc_cnt_d = tick ? '0 : presc_cnt_q + PCW'(1);
        pwm_cnt_d   = tick ? pwm_cnt_q + PWM_W'(1) : pwm_cnt_q;
        pend_d      = period_end;
        pwm_d       = '0;
        duty_sh_d   = duty_sh_q;
        for (int c = 0; c < 3; c++) begin
            // Compare against the old shadow: a newly loaded duty shows from the next period's first tick.
            pwm_d[c]     = ({1'b0, pwm_cnt_q} < duty_sh_q[c]);
            duty_sh_d[c] = period_end ? sat_duty(duty_in[c]) : duty_sh_q[c];
        end
        {led_blink_d, bl_cnt_d} = sq_next(bus.LED_FREQ, bl_cnt_q, led_blink_q);
        {bz_out_d, bz_cnt_d}    = sq_next(bus.BZ_FREQ, bz_cnt_q, bz_out_q);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            presc_cnt_q <= '0;
            pwm_cnt_q   <= '0;
            duty_sh_q   <= '0;
            pwm_q       <= '0;
            pend_q      <= 1'b0;
            bl_cnt_q    <= '0;
            led_blink_q <= 1'b0;
            bz_cnt_q    <= '0;
            bz_out_q    <= 1'b0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            duty_sh_q   <= duty_sh_d;
            pwm_q       <= pwm_d;
            pend_q      <= pend_d;
            bl_cnt_q    <= bl_cnt_d;
            led_blink_q <= led_blink_d;
            bz_cnt_q    <= bz_cnt_d;
            bz_out_q    <= bz_out_d;
        end
    end

    assign bus.LED_BLINK      = led_blink_q;
    assign bus.BZ_OUT         = bz_out_q;
    assign bus.LEDR_PWM       = pwm_q[0];
    assign bus.LEDG_PWM       = pwm_q[1];
    assign bus.LEDB_PWM       = pwm_q[2];
    assign bus.PWM_PERIOD_END = pend_q;
endmodule

// File: tb/tb_perip_led_bz_pwm.sv
// Bench for perip_led_bz_pwm with PRESC=2, PWM_W=4 (32-cycle PWM period).
// Table vectors, hand sequences for the multi-cycle corners, then random stimulus against a timeline model.
module tb_perip_led_bz_pwm;
    localparam int P   = 2;
    localparam int W   = 4;
    localparam int PER = P * (1 << W);

    logic CLK = 1'b0;
    logic RST = 1'b1;

    perip_led_bz_pwm_if bus ();

    perip_led_bz_pwm #(.PWM_W(W), .PRESC(P)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Model: position in the PWM timeline is just the count of edges since reset.
    longint     k;
    longint     sh [3];
    longint     bl_age, bz_age;
    logic       bl_o, bz_o, pend_o;
    logic [2:0] pwm_o;

    function automatic longint sat(input logic [31:0] d);
        return (d > 32'(1 << W)) ? longint'(1 << W) : longint'(d);
    endfunction

    task automatic wave(input logic [31:0] f, inout longint age, inout logic o);
        if (f == 32'd0) begin
            age = 0;
            o   = 1'b0;
        end else if (age + 1 >= longint'(f)) begin
            age = 0;
            o   = ~o;
        end else begin
            age = age + 1;
        end
    endtask

    task automatic model_edge();
        longint duty [3];
        longint pos;
        logic   pe;
        duty[0] = longint'(bus.LEDR_Puty);
        duty[1] = longint'(bus.LEDG_Puty);
        duty[2] = longint'(bus.LEDB_Puty);
        if (RST) begin
            k = 0;
            for (int i = 0; i < 3; i++) sh[i] = 0;
            bl_age = 0; bz_age = 0;
            bl_o = 1'b0; bz_o = 1'b0; pend_o = 1'b0; pwm_o = 3'b000;
        end else begin
            pe  = ((k % PER) == PER - 1);
            pos = (k / P) % (1 << W);
            for (int i = 0; i < 3; i++) pwm_o[i] = (pos < sh[i]);
            pend_o = pe;
            if (pe) for (int i = 0; i < 3; i++) sh[i] = sat(duty[i][31:0]);
            k = k + 1;
            wave(bus.LED_FREQ, bl_age, bl_o);
            wave(bus.BZ_FREQ, bz_age, bz_o);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [5:0] dut_vec();
        return {bus.LED_BLINK, bus.BZ_OUT, bus.LEDR_PWM, bus.LEDG_PWM, bus.LEDB_PWM,
                bus.PWM_PERIOD_END};
    endfunction

    function automatic logic [5:0] model_vec();
        return {bl_o, bz_o, pwm_o[0], pwm_o[1], pwm_o[2], pend_o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic [31:0] lf, input logic [31:0] bf, input logic [31:0] r,
                          input logic [31:0] g, input logic [31:0] b);
        bus.LED_FREQ  = lf;
        bus.BZ_FREQ   = bf;
        bus.LEDR_Puty = r;
        bus.LEDG_Puty = g;
        bus.LEDB_Puty = b;
    endtask

    task automatic do_reset(input int n);
        RST = 1'b1;
        repeat (n) step();
        RST = 1'b0;
    endtask

    // exp bits: {LED_BLINK, BZ_OUT, LEDR_PWM, LEDG_PWM, LEDB_PWM, PWM_PERIOD_END} after n edges out of reset
    typedef struct {
        logic [31:0] lf, bf, r, g, b;
        int          n;
        logic [5:0]  exp;
    } vec_t;

    vec_t tbl [9];
    int   hi;

    initial begin
        set_in(0, 0, 0, 0, 0);
        k = 0; bl_age = 0; bz_age = 0;
        bl_o = 0; bz_o = 0; pend_o = 0; pwm_o = '0;
        for (int i = 0; i < 3; i++) sh[i] = 0;

        tbl[0] = '{5, 3, 4,  0, 16,           33, 6'b011010};
        tbl[1] = '{5, 3, 4,  0, 16,           40, 6'b011010};
        tbl[2] = '{5, 3, 4,  0, 16,           41, 6'b010010};
        tbl[3] = '{5, 3, 4,  0, 16,           32, 6'b000001};
        tbl[4] = '{7, 3, 12, 0, 32'hFFFFFFFF, 56, 6'b001010};
        tbl[5] = '{7, 3, 12, 0, 32'hFFFFFFFF, 57, 6'b010010};
        tbl[6] = '{0, 0, 16, 1, 2,            70, 6'b001000};
        tbl[7] = '{1, 2, 0,  0, 0,             9, 6'b100000};
        tbl[8] = '{1, 2, 0,  0, 0,            64, 6'b000001};

        do_reset(2);
        check("reset_state", 32'(dut_vec()), 32'd0);

        for (int i = 0; i < 9; i++) begin
            set_in(tbl[i].lf, tbl[i].bf, tbl[i].r, tbl[i].g, tbl[i].b);
            do_reset(2);
            repeat (tbl[i].n) step();
            check($sformatf("vec%0d", i), 32'(dut_vec()), 32'(tbl[i].exp));
        end

        // Mid-period duty change: current period stays at 8 high, next one is 24 high.
        set_in(0, 0, 4, 0, 0);
        do_reset(2);
        repeat (32) step();
        check("first_period_end", 32'(bus.PWM_PERIOD_END), 32'd1);
        hi = 0;
        for (int i = 0; i < 32; i++) begin
            if (i == 7) bus.LEDR_Puty = 32'd12;
            step();
            hi += int'(bus.LEDR_PWM);
        end
        check("duty_old_period_high", 32'(hi), 32'd8);
        check("second_period_end", 32'(bus.PWM_PERIOD_END), 32'd1);
        hi = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            hi += int'(bus.LEDR_PWM);
        end
        check("duty_new_period_high", 32'(hi), 32'd24);

        // Buzzer period cut from 100 to 10 while the count is at 50.
        set_in(0, 100, 0, 0, 0);
        do_reset(2);
        repeat (50) step();
        check("bz_before_cut", 32'(bus.BZ_OUT), 32'd0);
        bus.BZ_FREQ = 32'd10;
        step();
        check("bz_wrap_on_cut", 32'(bus.BZ_OUT), 32'd1);
        repeat (9) step();
        check("bz_hold_9", 32'(bus.BZ_OUT), 32'd1);
        step();
        check("bz_toggle_10", 32'(bus.BZ_OUT), 32'd0);

        // Blink every 5, then switched off.
        set_in(5, 0, 0, 0, 0);
        do_reset(2);
        repeat (4) step();
        check("blink_4", 32'(bus.LED_BLINK), 32'd0);
        step();
        check("blink_5", 32'(bus.LED_BLINK), 32'd1);
        repeat (5) step();
        check("blink_10", 32'(bus.LED_BLINK), 32'd0);
        repeat (5) step();
        check("blink_15", 32'(bus.LED_BLINK), 32'd1);
        bus.LED_FREQ = 32'd0;
        step();
        check("blink_off", 32'(bus.LED_BLINK), 32'd0);
        hi = 0;
        repeat (12) begin
            step();
            hi += int'(bus.LED_BLINK);
        end
        check("blink_stays_off", 32'(hi), 32'd0);

        // Reset asserted mid-run, then everything restarts.
        set_in(7, 3, 10, 10, 10);
        do_reset(2);
        repeat (100) begin
            step();
            check("run_pre_rst", 32'(dut_vec()), 32'(model_vec()));
        end
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("mid_rst_%0d", i), 32'(dut_vec()), 32'd0);
        end
        RST = 1'b0;
        repeat (100) begin
            step();
            check("run_post_rst", 32'(dut_vec()), 32'(model_vec()));
        end

        // Random settings changes and reset pulses against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 4))
                    0: bus.LED_FREQ  = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
                    1: bus.BZ_FREQ   = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
                    2: bus.LEDR_Puty = ($urandom_range(0, 5) == 0) ? $urandom() : 32'($urandom_range(0, 18));
                    3: bus.LEDG_Puty = ($urandom_range(0, 5) == 0) ? $urandom() : 32'($urandom_range(0, 18));
                    default: bus.LEDB_Puty = ($urandom_range(0, 5) == 0) ? $urandom() : 32'($urandom_range(0, 18));
                endcase
            end
            RST = ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0;
            step();
            check("random", 32'(dut_vec()), 32'(model_vec()));
        end
        RST = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
